// File: rtl/mersenne_pkg.sv
// Shared definitions for the Mersenne trial-factor exponentiation sequencer:
// default widths, divider operand width and the sequencer state type.
package mersenne_pkg;

   localparam int P_W_DEFAULT = 16;
   localparam int Q_W_DEFAULT = 16;
   localparam int DIV_W       = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SQUARE,
      ST_DIV_REQ,
      ST_DIV_WAIT,
      ST_DOUBLE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/modexp_ctrl_mod_double.sv
// Conditional modular doubling: y = en ? (2r mod q) : r, assuming r < q.
module mod_double #(
   parameter int Q_W = 16
) (
   input  logic [Q_W-1:0] r,
   input  logic [Q_W-1:0] q,
   input  logic           en,
   output logic [Q_W-1:0] y
);

   logic [Q_W:0] t;

   assign t = {r, 1'b0};

   always_comb begin
      // NOTE: default assignment first so every path drives y and no latch is inferred.
      y = r;
      if (en) begin
         y = (t >= {1'b0, q}) ? Q_W'(t - {1'b0, q}) : t[Q_W-1:0];
      end
   end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right binary exponentiation sequencer computing 2^p mod q, using an
// external 32-bit remainder engine for the reduction after each square.
module modexp_ctrl
   import mersenne_pkg::*;
#(
   parameter int P_W = P_W_DEFAULT,
   parameter int Q_W = Q_W_DEFAULT
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             start,
   input  logic [P_W-1:0]   exponent,
   input  logic [Q_W-1:0]   modulus,
   output logic             busy,
   output logic             done,
   output logic [Q_W-1:0]   result,
   output logic             is_factor,
   output logic             invalid,
   output logic             div_start,
   output logic [DIV_W-1:0] div_numerator,
   output logic [DIV_W-1:0] div_denominator,
   input  logic [DIV_W-1:0] div_remainder,
   input  logic             div_finished
);

   localparam int IDX_W = (P_W > 1) ? $clog2(P_W) : 1;

   state_t           state;
   logic [P_W-1:0]   exp_reg;
   logic [Q_W-1:0]   q_reg;
   logic [Q_W-1:0]   r;
   logic [Q_W-1:0]   r_dbl;
   logic [IDX_W-1:0] idx;
   logic [2*Q_W-1:0] sq_reg;
   logic             unused_rem_hi;

   // Operands come straight from registers that only change outside DIV_WAIT.
   assign div_start       = (state == ST_DIV_REQ);
   assign div_numerator   = DIV_W'(sq_reg);
   assign div_denominator = DIV_W'(q_reg);
   assign unused_rem_hi   = ^div_remainder[DIV_W-1:Q_W];

   mod_double #(.Q_W(Q_W)) u_mod_double (
      .r  (r),
      .q  (q_reg),
      .en (exp_reg[idx]),
      .y  (r_dbl)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         is_factor <= 1'b0;
         invalid   <= 1'b0;
         exp_reg   <= '0;
         q_reg     <= '0;
         r         <= '0;
         idx       <= '0;
         sq_reg    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  exp_reg <= exponent;
                  q_reg   <= modulus;
                  busy    <= 1'b1;
                  state   <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (q_reg < Q_W'(2)) begin
                  invalid <= 1'b1;
                  result  <= '0;
                  r       <= '0;
                  state   <= ST_DONE;
               end else begin
                  invalid <= 1'b0;
                  r       <= Q_W'(1);
                  idx     <= IDX_W'(P_W - 1);
                  state   <= ST_SQUARE;
               end
            end
            ST_SQUARE: begin
               sq_reg <= {{Q_W{1'b0}}, r} * {{Q_W{1'b0}}, r};
               state  <= ST_DIV_REQ;
            end
            ST_DIV_REQ: begin
               state <= ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
               if (div_finished) begin
                  r     <= div_remainder[Q_W-1:0];
                  state <= ST_DOUBLE;
               end
            end
            ST_DOUBLE: begin
               r <= r_dbl;
               if (idx == '0) begin
                  state <= ST_DONE;
               end else begin
                  idx   <= idx - 1'b1;
                  state <= ST_SQUARE;
               end
            end
            ST_DONE: begin
               result    <= r;
               is_factor <= (r == Q_W'(1)) && !invalid;
               done      <= 1'b1;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
